// File: rtl/fourier_srg_dft_pkg.sv
// +----------------------------------------------------------------------------+
// | fourier_srg_dft_pkg : shared types, widths and twiddle helpers for the DFT  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package fourier_srg_dft_pkg;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_LOAD = 2'b01,
        OP_PROC = 2'b10,
        OP_READ = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int DEF_TW_FRAC = 14;
    localparam int ACC_W       = 48;
    localparam int DATA_W      = 32;
    localparam int TW_W        = 16;
    localparam real PI         = 3.14159265358979323846;

    // Elaboration-time only: builds the constant twiddle tables.
    function automatic logic signed [TW_W-1:0] tw_cos(input int idx, input int n, input int frac);
        real v;
        v = $cos(2.0 * PI * real'(idx) / real'(n)) * real'(1 << frac);
        return TW_W'(integer'(v));
    endfunction

    function automatic logic signed [TW_W-1:0] tw_sin(input int idx, input int n, input int frac);
        real v;
        v = $sin(2.0 * PI * real'(idx) / real'(n)) * real'(1 << frac);
        return TW_W'(integer'(v));
    endfunction

endpackage

`default_nettype wire

// File: rtl/fourier_srg_dft_if.sv
// +----------------------------------------------------------------------------+
// | fourier_srg_dft_if : host-side opcode/address/data bus of the DFT engine   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface fourier_srg_dft_if;
    logic        [31:0] addr;
    logic signed [31:0] x;
    logic        [1:0]  operation;
    logic signed [31:0] y_re;
    logic signed [31:0] y_im;
    logic               done;

    modport master (output addr, x, operation, input y_re, y_im, done);
    modport slave  (input addr, x, operation, output y_re, y_im, done);
endinterface

`default_nettype wire

// File: rtl/fourier_srg_dft_twiddle_rom.sv
// +----------------------------------------------------------------------------+
// | fourier_srg_dft_twiddle_rom : idx -> cos/sin(2*pi*idx/N) in signed Q1.FRAC |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module fourier_srg_dft_twiddle_rom
    import fourier_srg_dft_pkg::*;
#(
    parameter int N       = 10,
    parameter int TW_FRAC = DEF_TW_FRAC
) (
    input  wire logic        [$clog2(N)-1:0] idx,
    output      logic signed [TW_W-1:0]      cos_tw,
    output      logic signed [TW_W-1:0]      sin_tw
);

    logic signed [TW_W-1:0] w_cos_tab [N];
    logic signed [TW_W-1:0] w_sin_tab [N];

    for (genvar g = 0; g < N; g++) begin : g_tab
        assign w_cos_tab[g] = tw_cos(g, N, TW_FRAC);
        assign w_sin_tab[g] = tw_sin(g, N, TW_FRAC);
    end

    assign cos_tw = w_cos_tab[idx];
    assign sin_tw = w_sin_tab[idx];

endmodule

`default_nettype wire

// File: rtl/fourier_srg_dft.sv
// +----------------------------------------------------------------------------+
// | fourier_srg_dft : sequential N-point real-input DFT, one MAC pair / cycle  |
// | Optional FOURIER_ROUND_EN: round-half-up scaling instead of floor.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module fourier_srg_dft
    import fourier_srg_dft_pkg::*;
#(
    parameter int N       = 10,
    parameter int TW_FRAC = DEF_TW_FRAC
) (
    input wire logic         clk,
    input wire logic         reset,
    fourier_srg_dft_if.slave bus
);

    localparam int                       IDX_W  = $clog2(N);
    localparam logic [IDX_W-1:0]         N_LAST = IDX_W'(N - 1);
    localparam logic [IDX_W:0]           N_WRAP = (IDX_W + 1)'(N);
`ifdef FOURIER_ROUND_EN
    localparam logic signed [ACC_W-1:0]  RND    = ACC_W'(1) << (TW_FRAC - 1);
`else
    localparam logic signed [ACC_W-1:0]  RND    = '0;
`endif

    state_t                    r_state, w_state_nxt;
    op_t                       w_op;
    logic                      w_start, w_mac, w_abort;
    logic signed [DATA_W-1:0]  r_smp    [N];
    logic signed [DATA_W-1:0]  r_res_re [N];
    logic signed [DATA_W-1:0]  r_res_im [N];
    logic        [IDX_W-1:0]   r_k, r_n, r_idx, w_idx_nxt, w_addr_idx;
    logic        [IDX_W:0]     w_idx_sum;
    logic                      w_addr_ok;
    logic signed [ACC_W-1:0]   r_acc_re, r_acc_im, w_acc_re_sum, w_acc_im_sum;
    logic signed [ACC_W-1:0]   w_prod_re, w_prod_im;
    logic signed [TW_W-1:0]    w_cos, w_sin;
    logic                      r_done;

    assign w_op       = op_t'(bus.operation);
    assign w_addr_ok  = bus.addr < 32'(N);
    assign w_addr_idx = bus.addr[IDX_W-1:0];

    fourier_srg_dft_twiddle_rom #(.N(N), .TW_FRAC(TW_FRAC)) u_rom (
        .idx    (r_idx),
        .cos_tw (w_cos),
        .sin_tw (w_sin)
    );

    // Twiddle index tracks (k*n) mod N incrementally: add k, fold once.
    assign w_idx_sum = {1'b0, r_idx} + {1'b0, r_k};
    assign w_idx_nxt = (w_idx_sum >= N_WRAP) ? IDX_W'(w_idx_sum - N_WRAP) : IDX_W'(w_idx_sum);

    assign w_prod_re    = r_smp[r_n] * w_cos;
    assign w_prod_im    = r_smp[r_n] * w_sin;
    assign w_acc_re_sum = r_acc_re + w_prod_re;
    assign w_acc_im_sum = r_acc_im - w_prod_im;

    always_ff @(posedge clk) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // DONE falls back to IDLE once the opcode leaves 10 so the next 10 restarts.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_mac       = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_op == OP_PROC) begin
                    w_state_nxt = CALC;
                    w_start     = 1'b1;
                end
            end
            CALC: begin
                if (w_op != OP_PROC) begin
                    w_state_nxt = IDLE;
                    w_abort     = 1'b1;
                end else begin
                    w_mac = 1'b1;
                    if (r_k == N_LAST && r_n == N_LAST) w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (w_op != OP_PROC) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_op == OP_LOAD && w_addr_ok) r_smp[w_addr_idx] <= bus.x;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_k      <= '0;
            r_n      <= '0;
            r_idx    <= '0;
            r_acc_re <= '0;
            r_acc_im <= '0;
            r_done   <= 1'b0;
            for (int i = 0; i < N; i++) begin
                r_res_re[i] <= '0;
                r_res_im[i] <= '0;
            end
        end else if (w_start) begin
            r_k      <= '0;
            r_n      <= '0;
            r_idx    <= '0;
            r_acc_re <= '0;
            r_acc_im <= '0;
            r_done   <= 1'b0;
        end else if (w_abort) begin
            r_done <= 1'b0;
        end else if (w_mac) begin
            if (r_n == N_LAST) begin
                r_res_re[r_k] <= DATA_W'((w_acc_re_sum + RND) >>> TW_FRAC);
                r_res_im[r_k] <= DATA_W'((w_acc_im_sum + RND) >>> TW_FRAC);
                r_acc_re      <= '0;
                r_acc_im      <= '0;
                r_n           <= '0;
                r_idx         <= '0;
                r_k           <= r_k + 1'b1;
                if (r_k == N_LAST) r_done <= 1'b1;
            end else begin
                r_acc_re <= w_acc_re_sum;
                r_acc_im <= w_acc_im_sum;
                r_n      <= r_n + 1'b1;
                r_idx    <= w_idx_nxt;
            end
        end
    end

    always_comb begin
        bus.y_re = '0;
        bus.y_im = '0;
        if (w_op == OP_READ && w_addr_ok) begin
            bus.y_re = r_res_re[w_addr_idx];
            bus.y_im = r_res_im[w_addr_idx];
        end
    end

    assign bus.done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_fourier_srg_dft.sv
// +----------------------------------------------------------------------------+
// | tb_fourier_srg_dft : directed self-checking bench for fourier_srg_dft (N=10)|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fourier_srg_dft;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    fourier_srg_dft_if bus ();

    fourier_srg_dft #(.N(10), .TW_FRAC(14)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk_eq(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_tol(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert ((obs - exp) <= 1 && (exp - obs) <= 1) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d+-1", tag, obs, exp);
        end
    endtask

    task automatic load(input int a, input int v);
        @(negedge clk);
        bus.operation = 2'b01;
        bus.addr      = a;
        bus.x         = v;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) begin
            @(negedge clk);
            bus.operation = 2'b00;
        end
    endtask

    task automatic rd(input int a, output logic signed [31:0] re, output logic signed [31:0] im);
        @(negedge clk);
        bus.operation = 2'b11;
        bus.addr      = a;
        #1;
        re = bus.y_re;
        im = bus.y_im;
    endtask

    task automatic run_proc(output int cyc);
        @(negedge clk);
        bus.operation = 2'b10;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (bus.done !== 1'b1 && cyc < 300);
    endtask

    initial begin
        logic signed [31:0] re, im, b1_re, b1_im;
        int cyc;

        bus.operation = 2'b00;
        bus.addr      = '0;
        bus.x         = '0;
        reset         = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        chk_eq("reset_done", 32'(bus.done), 0);
        rd(0, re, im);
        chk_eq("reset_re0", re, 0);
        chk_eq("reset_im0", im, 0);

        // Ramp x[n] = n
        for (int n = 0; n < 10; n++) load(n, n);
        run_proc(cyc);
        chk_eq("ramp_latency", cyc, 101);
        idle(1);
        rd(0, re, im);
        chk_eq("ramp_b0_re", re, 45);
        chk_eq("ramp_b0_im", im, 0);
        rd(1, re, im);
        b1_re = re;
        b1_im = im;
        chk_tol("ramp_b1_re", re, -5);
        chk_tol("ramp_b1_im", im, 15);
        rd(5, re, im);
        chk_tol("ramp_b5_re", re, -5);
        chk_tol("ramp_b5_im", im, 0);
        rd(9, re, im);
        chk_tol("ramp_b9_im", im, -15);
        rd(10, re, im);
        chk_eq("oob_read_re", re, 0);
        chk_eq("oob_read_im", im, 0);
        chk_eq("done_hold_read", 32'(bus.done), 1);

        // Out-of-range load, then recompute the same data
        load(12, 999);
        run_proc(cyc);
        chk_eq("repeat_latency", cyc, 101);
        repeat (5) @(negedge clk);
        chk_eq("done_held_proc", 32'(bus.done), 1);
        rd(0, re, im);
        chk_eq("repeat_b0_re", re, 45);
        rd(1, re, im);
        chk_eq("repeat_b1_re", re, b1_re);
        chk_eq("repeat_b1_im", im, b1_im);

        // Impulse
        load(0, 1000);
        for (int n = 1; n < 10; n++) load(n, 0);
        run_proc(cyc);
        chk_eq("imp_latency", cyc, 101);
        for (int k = 0; k < 10; k++) begin
            rd(k, re, im);
            chk_eq($sformatf("imp_b%0d_re", k), re, 1000);
            chk_eq($sformatf("imp_b%0d_im", k), im, 0);
        end

        // Constant negative input
        for (int n = 0; n < 10; n++) load(n, -7);
        run_proc(cyc);
        rd(0, re, im);
        chk_eq("const_b0_re", re, -70);
        chk_eq("const_b0_im", im, 0);
        for (int k = 1; k < 10; k++) begin
            rd(k, re, im);
            chk_tol($sformatf("const_b%0d_re", k), re, 0);
            chk_tol($sformatf("const_b%0d_im", k), im, 0);
        end

        // Reset 40 cycles into a computation
        @(negedge clk);
        bus.operation = 2'b10;
        repeat (40) @(negedge clk);
        reset         = 1'b0;
        bus.operation = 2'b00;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_eq("midreset_done", 32'(bus.done), 0);
        for (int k = 0; k < 10; k++) begin
            rd(k, re, im);
            chk_eq($sformatf("midreset_b%0d_re", k), re, 0);
            chk_eq($sformatf("midreset_b%0d_im", k), im, 0);
        end

        // Abort by dropping the opcode after 20 cycles: bin0 finished, bin1 not
        for (int n = 0; n < 10; n++) load(n, n);
        @(negedge clk);
        bus.operation = 2'b10;
        repeat (20) @(negedge clk);
        bus.operation = 2'b00;
        repeat (5) @(negedge clk);
        chk_eq("abort_done", 32'(bus.done), 0);
        rd(0, re, im);
        chk_eq("abort_b0_re", re, 45);
        rd(1, re, im);
        chk_eq("abort_b1_re", re, 0);
        chk_eq("abort_b1_im", im, 0);

        idle(1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
